turbo_enc_sched: RTL and testbench

//  Sequences one turbo-code block through two RSC constituent encoders (the 3-register

---
 rtl/turbo_pkg.sv | 24 ++
 rtl/turbo_enc_sched_if.sv | 51 +++++
 rtl/turbo_enc_phase_cnt.sv | 32 +++
 rtl/turbo_enc_sched.sv | 153 +++++++++++++++
 tb/tb_turbo_enc_sched.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/turbo_pkg.sv
// Shared constants and types for the turbo encoder block scheduler.
package turbo_pkg;

  localparam int unsigned K_SMALL  = 1056;
  localparam int unsigned K_LARGE  = 6144;
  localparam int unsigned TAIL_LEN = 3;
  localparam int unsigned AW       = 13;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DATA,
    TAIL1,
    TAIL2
  } state_e;

  typedef struct packed {
    logic sys;
    logic p1;
    logic p2;
    logic tail;
  } triplet_t;

endpackage

// File: rtl/turbo_enc_sched_if.sv
// Scheduler bus: block request, dual-read bit buffer, two RSC encoders, triplet stream.
interface turbo_enc_sched_if;
  import turbo_pkg::*;

  logic          start;
  logic          k_sel;
  logic          ready;
  logic          busy;

  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic          mem_pi_rd;
  logic [AW-1:0] mem_idx;
  logic          mem_bit;
  logic          mem_pi_bit;

  logic          enc1_en;
  logic          enc2_en;
  logic          enc1_ck;
  logic          enc2_ck;
  logic          enc1_term;
  logic          enc2_term;
  logic          enc1_xt;
  logic          enc2_xt;
  logic          enc1_zk;
  logic          enc2_zk;

  logic          out_valid;
  logic          out_sys;
  logic          out_p1;
  logic          out_p2;
  logic          out_tail;
  logic          block_done;

  modport master (
    input  start, k_sel, mem_bit, mem_pi_bit,
           enc1_xt, enc2_xt, enc1_zk, enc2_zk,
    output ready, busy, mem_rd, mem_addr, mem_pi_rd, mem_idx,
           enc1_en, enc2_en, enc1_ck, enc2_ck, enc1_term, enc2_term,
           out_valid, out_sys, out_p1, out_p2, out_tail, block_done
  );

  modport slave (
    output start, k_sel, mem_bit, mem_pi_bit,
           enc1_xt, enc2_xt, enc1_zk, enc2_zk,
    input  ready, busy, mem_rd, mem_addr, mem_pi_rd, mem_idx,
           enc1_en, enc2_en, enc1_ck, enc2_ck, enc1_term, enc2_term,
           out_valid, out_sys, out_p1, out_p2, out_tail, block_done
  );

endinterface

// File: rtl/turbo_enc_phase_cnt.sv
// Loadable down-counter with terminal-count flag; saturates at zero.
module turbo_enc_phase_cnt import turbo_pkg::*; (
  input  logic          clk,
  input  logic          aclr,
  input  logic          load_i,
  input  logic [AW-1:0] load_val_i,
  input  logic          dec_i,
  output logic          tc_o
);

  logic [AW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/turbo_enc_sched.sv
// Turbo block scheduler: fetches natural/interleaved bits, drives two RSC encoders
// through data and back-to-back termination phases, emits registered triplets.
module turbo_enc_sched #(
  parameter int unsigned K_SMALL = turbo_pkg::K_SMALL,
  parameter int unsigned K_LARGE = turbo_pkg::K_LARGE
) (
  input logic                clk,
  input logic                aclr,
  turbo_enc_sched_if.master  bus
);
  import turbo_pkg::*;

  localparam logic [AW-1:0] KS_LAST   = AW'(K_SMALL - 1);
  localparam logic [AW-1:0] KL_LAST   = AW'(K_LARGE - 1);
  localparam logic [AW-1:0] TAIL_LAST = AW'(TAIL_LEN - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  triplet_t      trip_q, trip_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;

  logic          idle;
  logic          accept;
  logic          rd;
  logic          tc;
  logic          cnt_load;
  logic          cnt_dec;
  logic [AW-1:0] cnt_val;

  // Ready waits for the last tail triplet to leave the output register.
  assign idle   = (state_q == IDLE) && !valid_q;
  assign accept = bus.start && idle;

  // One counter times every phase; K-1 is captured on accept, so k_sel is ignored while busy.
  turbo_enc_phase_cnt u_phase_cnt (
    .clk        (clk),
    .aclr       (aclr),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .tc_o       (tc)
  );

  always_ff @(posedge clk) begin
    if (aclr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = FETCH;
          cnt_load = 1'b1;
          cnt_val  = bus.k_sel ? KL_LAST : KS_LAST;
        end
      end
      FETCH: state_d = DATA;
      DATA, TAIL1: begin
        if (tc) begin
          state_d  = (state_q == DATA) ? TAIL1 : TAIL2;
          cnt_load = 1'b1;
          cnt_val  = TAIL_LAST;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      TAIL2: begin
        if (tc) begin
          state_d = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reads run one cycle ahead of the encoders: FETCH plus all but the last DATA cycle.
  always_comb begin
    rd            = (state_q == FETCH) || ((state_q == DATA) && !tc);
    addr_d        = (state_q == IDLE) ? '0 : (rd ? addr_q + 1'b1 : addr_q);
    bus.ready     = idle;
    bus.busy      = !idle;
    bus.mem_rd    = rd;
    bus.mem_pi_rd = rd;
    bus.mem_addr  = rd ? addr_q : '0;
    bus.mem_idx   = rd ? addr_q : '0;
    bus.enc1_en   = 1'b0;
    bus.enc2_en   = 1'b0;
    bus.enc1_ck   = 1'b0;
    bus.enc2_ck   = 1'b0;
    bus.enc1_term = 1'b0;
    bus.enc2_term = 1'b0;
    trip_d        = '0;
    valid_d       = 1'b0;
    done_d        = 1'b0;
    unique case (state_q)
      DATA: begin
        bus.enc1_en = 1'b1;
        bus.enc2_en = 1'b1;
        bus.enc1_ck = bus.mem_bit;
        bus.enc2_ck = bus.mem_pi_bit;
        trip_d      = '{sys: bus.mem_bit, p1: bus.enc1_zk, p2: bus.enc2_zk, tail: 1'b0};
        valid_d     = 1'b1;
      end
      TAIL1: begin
        bus.enc1_en   = 1'b1;
        bus.enc1_term = 1'b1;
        trip_d        = '{sys: bus.enc1_xt, p1: bus.enc1_zk, p2: 1'b0, tail: 1'b1};
        valid_d       = 1'b1;
      end
      TAIL2: begin
        bus.enc2_en   = 1'b1;
        bus.enc2_term = 1'b1;
        trip_d        = '{sys: bus.enc2_xt, p1: 1'b0, p2: bus.enc2_zk, tail: 1'b1};
        valid_d       = 1'b1;
        done_d        = tc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      addr_q  <= '0;
      trip_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      trip_q  <= trip_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_sys    = trip_q.sys;
  assign bus.out_p1     = trip_q.p1;
  assign bus.out_p2     = trip_q.p2;
  assign bus.out_tail   = trip_q.tail;
  assign bus.block_done = done_q;

endmodule

// File: tb/tb_turbo_enc_sched.sv
// Directed bench: bit-buffer and RSC encoder models around the scheduler, per-cycle checks.
module tb_turbo_enc_sched;

  logic clk = 1'b0;
  logic aclr;
  always #5 clk = ~clk;

  turbo_enc_sched_if bus ();

  turbo_enc_sched dut (
    .clk  (clk),
    .aclr (aclr),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  bit          buf_a  [8192];
  int unsigned pi_tab [8192];
  logic [3:0]  exp_q  [$];
  logic [3:0]  first_trip;

  // Dual-read buffer: data returns the cycle after the strobe.
  always @(posedge clk) begin
    if (aclr) begin
      bus.mem_bit    <= 1'b0;
      bus.mem_pi_bit <= 1'b0;
    end else begin
      if (bus.mem_rd)    bus.mem_bit    <= buf_a[bus.mem_addr];
      if (bus.mem_pi_rd) bus.mem_pi_bit <= buf_a[pi_tab[bus.mem_idx]];
    end
  end

  // RSC encoders: e[0]=s1, e[1]=s2, e[2]=s3; feedback 1+D^2+D^3, parity 1+D+D^3.
  logic [2:0] e1, e2;
  logic       a1, a2;
  always_comb begin
    bus.enc1_xt = e1[1] ^ e1[2];
    a1          = (bus.enc1_term ? bus.enc1_xt : bus.enc1_ck) ^ e1[1] ^ e1[2];
    bus.enc1_zk = a1 ^ e1[0] ^ e1[2];
    bus.enc2_xt = e2[1] ^ e2[2];
    a2          = (bus.enc2_term ? bus.enc2_xt : bus.enc2_ck) ^ e2[1] ^ e2[2];
    bus.enc2_zk = a2 ^ e2[0] ^ e2[2];
  end
  always @(posedge clk) begin
    if (aclr) begin
      e1 <= '0;
      e2 <= '0;
    end else begin
      if (bus.enc1_en) e1 <= {e1[1], e1[0], a1};
      if (bus.enc2_en) e2 <= {e2[1], e2[0], a2};
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Golden stream: K data triplets, 3 encoder-1 tails, 3 encoder-2 tails.
  task automatic build_exp(input int k);
    logic [2:0] s1, s2;
    logic       a, z1, z2, xt, u, v;
    s1 = '0;
    s2 = '0;
    exp_q.delete();
    for (int i = 0; i < k; i++) begin
      u  = buf_a[i];
      v  = buf_a[pi_tab[i]];
      a  = u ^ s1[1] ^ s1[2];
      z1 = a ^ s1[0] ^ s1[2];
      s1 = {s1[1], s1[0], a};
      a  = v ^ s2[1] ^ s2[2];
      z2 = a ^ s2[0] ^ s2[2];
      s2 = {s2[1], s2[0], a};
      exp_q.push_back({u, z1, z2, 1'b0});
    end
    for (int i = 0; i < 3; i++) begin
      xt = s1[1] ^ s1[2];
      z1 = s1[0] ^ s1[2];
      s1 = {s1[1], s1[0], 1'b0};
      exp_q.push_back({xt, z1, 1'b0, 1'b1});
    end
    for (int i = 0; i < 3; i++) begin
      xt = s2[1] ^ s2[2];
      z2 = s2[0] ^ s2[2];
      s2 = {s2[1], s2[0], 1'b0};
      exp_q.push_back({xt, 1'b0, z2, 1'b1});
    end
  endtask

  // Starts a block in the current cycle t and checks cycles t+1..t+K+9; returns in t+K+9.
  task automatic run_block(input int k, input bit ksel, input int ign_at, input int abort_at);
    logic        rd_exp;
    logic [12:0] a_exp;
    logic [5:0]  enc_exp;
    logic [4:0]  out_exp;
    build_exp(k);
    chk("pre_ready", 0, 32'(bus.ready), 32'd1);
    bus.start = 1'b1;
    bus.k_sel = ksel;
    for (int c = 1; c <= k + 9; c++) begin
      tick();
      bus.start = 1'b0;
      bus.k_sel = ~ksel;
      rd_exp = (c <= k);
      a_exp  = rd_exp ? 13'(c - 1) : 13'd0;
      if (c >= 2 && c <= k + 1)
        enc_exp = {4'b1100, buf_a[c-2], buf_a[pi_tab[c-2]]};
      else if (c >= k + 2 && c <= k + 4)
        enc_exp = 6'b101000;
      else if (c >= k + 5 && c <= k + 7)
        enc_exp = 6'b010100;
      else
        enc_exp = 6'b000000;
      out_exp = (c >= 3 && c <= k + 8) ? {1'b1, exp_q[c-3]} : 5'b00000;
      chk("rd", c, {bus.mem_rd, bus.mem_pi_rd}, {rd_exp, rd_exp});
      chk("addr", c, {bus.mem_addr, bus.mem_idx}, {a_exp, a_exp});
      chk("enc", c, {bus.enc1_en, bus.enc2_en, bus.enc1_term, bus.enc2_term, bus.enc1_ck, bus.enc2_ck},
          32'(enc_exp));
      chk("trip", c, {bus.out_valid, bus.out_sys, bus.out_p1, bus.out_p2, bus.out_tail}, 32'(out_exp));
      chk("stat", c, {bus.block_done, bus.ready, bus.busy}, {c == k + 8, c == k + 9, c <= k + 8});
      if (c == 3) first_trip = {bus.out_sys, bus.out_p1, bus.out_p2, bus.out_tail};
      if (c == ign_at) begin
        bus.start = 1'b1;
        bus.k_sel = ~ksel;
      end
      if (c == abort_at) begin
        aclr = 1'b1;
        tick();
        aclr = 1'b0;
        chk("abort_ctl", c + 1, {bus.out_valid, bus.ready, bus.busy, bus.mem_rd, bus.enc1_en, bus.enc2_en},
            32'b010000);
        for (int j = 2; j <= 13; j++) begin
          tick();
          chk("abort_idle", c + j, {bus.block_done, bus.out_valid, bus.ready}, 32'b001);
        end
        chk("abort_enc_state", c + 13, {e1, e2}, 32'd0);
        return;
      end
    end
    chk("enc_state_zero", k + 9, {e1, e2}, 32'd0);
  endtask

  initial begin
    aclr      = 1'b1;
    bus.start = 1'b0;
    bus.k_sel = 1'b0;
    for (int i = 0; i < 8192; i++) begin
      buf_a[i]  = 1'b0;
      pi_tab[i] = i;
    end

    tick();
    tick();
    chk("rst_ready", 0, 32'(bus.ready), 32'd1);
    chk("rst_addr", 0, {bus.mem_addr, bus.mem_idx}, 32'd0);
    chk("rst_ctl", 0, {bus.busy, bus.mem_rd, bus.mem_pi_rd, bus.enc1_en, bus.enc2_en, bus.enc1_ck,
                       bus.enc2_ck, bus.enc1_term, bus.enc2_term, bus.out_valid, bus.out_sys,
                       bus.out_p1, bus.out_p2, bus.out_tail, bus.block_done}, 32'd0);

    // aclr and start in the same cycle: reset wins
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    aclr      = 1'b0;
    chk("aclr_beats_start", 0, {bus.ready, bus.busy, bus.mem_rd}, 32'b100);
    tick();
    chk("idle_after_rst", 0, {bus.ready, bus.busy, bus.mem_rd}, 32'b100);

    // All-zero block, K_SMALL
    run_block(1056, 1'b0, -1, -1);

    // Single one, identity pi, ignored start mid-block, then back-to-back K_LARGE block
    buf_a[0] = 1'b1;
    run_block(1056, 1'b0, 100, -1);
    chk("single_one_first", 3, 32'(first_trip), 32'b1110);
    for (int i = 0; i < 6144; i++) begin
      buf_a[i]  = 1'($urandom);
      pi_tab[i] = 6143 - i;
    end
    run_block(6144, 1'b1, -1, -1);

    // Mid-block reset, then a full block with a strided interleaver
    for (int i = 0; i < 1056; i++) begin
      buf_a[i]  = 1'($urandom);
      pi_tab[i] = (i * 13 + 7) % 1056;
    end
    run_block(1056, 1'b0, -1, 500);
    run_block(1056, 1'b0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
